// File: rtl/uart_pkg.sv
// Shared UART receive definitions: state encoding, default bit period, parity helper.
`timescale 1ns/1ps
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 32;

  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [ST_W-1:0] ST_START     = 3'd1;
  localparam logic [ST_W-1:0] ST_DATA      = 3'd2;
  localparam logic [ST_W-1:0] ST_PARITY    = 3'd3;
  localparam logic [ST_W-1:0] ST_STOP      = 3'd4;
  localparam logic [ST_W-1:0] ST_WAIT_IDLE = 3'd5;

  typedef enum logic [ST_W-1:0] {
    IDLE      = ST_IDLE,
    START     = ST_START,
    DATA      = ST_DATA,
    PARITY    = ST_PARITY,
    STOP      = ST_STOP,
    WAIT_IDLE = ST_WAIT_IDLE
  } state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       parity_err;
    logic       frame_err;
  } rx_result_t;

  // Expected parity bit: even parity is the XOR of the data, odd inverts it.
  function automatic logic parity_of(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: one mid_tick half a bit after restart, then a bit_tick every full bit.
`timescale 1ns/1ps
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic mid_tick,
  output logic bit_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;
  logic          half;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt  <= '0;
      half <= 1'b1;
    end else if (half && cnt == HALF_LAST) begin
      cnt  <= '0;
      half <= 1'b0;
    end else if (cnt == FULL_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign mid_tick = half && (cnt == HALF_LAST);
  assign bit_tick = !half && (cnt == FULL_LAST);

endmodule

// File: rtl/uart_rx_parity.sv
// UART receiver: start, 8 data bits LSB first, optional parity, stop -> byte plus error flags.
`timescale 1ns/1ps
module uart_rx_parity
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter bit PARITY_EN    = 1'b1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  logic       rx_meta, rx_s, rx_prev;
  state_t     state, state_nxt;
  logic [7:0] shreg;
  logic [3:0] bit_idx;
  logic       par_s;
  logic       restart, shift_en, par_cap, load;
  logic       mid_tick, bit_tick;
  rx_result_t res;

  // Synchroniser and edge history idle high so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .restart  (restart),
    .mid_tick (mid_tick),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    shift_en  = 1'b0;
    par_cap   = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (rx_prev && !rx_s) begin
          state_nxt = START;
          restart   = 1'b1;
        end
      end
      START: begin
        // Line back high at mid-start means a glitch, not a frame.
        if (mid_tick) state_nxt = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (bit_tick) begin
          shift_en = 1'b1;
          if (bit_idx == 4'd7) state_nxt = PARITY_EN ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_tick) begin
          par_cap   = 1'b1;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (bit_tick) begin
          load      = 1'b1;
          state_nxt = rx_s ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bit_idx <= '0;
      par_s   <= 1'b0;
    end else begin
      if (restart) bit_idx <= '0;
      else if (shift_en || par_cap) bit_idx <= bit_idx + 4'd1;
      if (shift_en) shreg <= {rx_s, shreg[7:1]};
      if (par_cap)  par_s <= rx_s;
    end
  end

  // Errored frames are still reported; the consumer decides what to drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      res   <= '0;
      valid <= 1'b0;
    end else begin
      valid <= load;
      if (load) begin
        res.data       <= shreg;
        res.parity_err <= PARITY_EN && (par_s != parity_of(shreg, PARITY_ODD));
        res.frame_err  <= !rx_s;
      end
    end
  end

  assign data       = res.data;
  assign parity_err = res.parity_err;
  assign frame_err  = res.frame_err;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_parity.sv
// Randomised frame stimulus checked against a frame-level model of the receiver.
`timescale 1ns/1ps
module tb_uart_rx_parity;

  localparam int CPB = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid, parity_err, frame_err, busy;

  uart_rx_parity #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         at;
  } exp_t;

  exp_t       q[$];
  logic [7:0] last_d  = 8'h00;
  logic       last_pe = 1'b0;
  logic       last_fe = 1'b0;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every valid must match the oldest outstanding frame, on the predicted cycle.
  always @(negedge clk) begin
    if (valid) begin : chk_valid
      exp_t e;
      if (q.size() == 0) begin
        chk("spurious_valid", 32'(valid), 32'd0);
      end else begin
        e = q.pop_front();
        chk("data", data, e.d);
        chk("parity_err", parity_err, e.pe);
        chk("frame_err", frame_err, e.fe);
        chk("valid_cycle", cyc, e.at);
        last_d  = e.d;
        last_pe = e.pe;
        last_fe = e.fe;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_held();
    chk("held_data", data, last_d);
    chk("held_parity_err", parity_err, last_pe);
    chk("held_frame_err", frame_err, last_fe);
  endtask

  task automatic chk_reset_vals();
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_parity_err", parity_err, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
  endtask

  // Drive one frame bit by bit; abort_bit >= 0 pulses rst mid-way through that bit
  // and abandons the frame with the line returned to idle.
  task automatic send_frame(input logic [7:0] d, input bit flip, input bit stop_v,
                            input int abort_bit);
    logic [10:0] bits;
    logic        par;
    exp_t        e;
    par  = logic'($countones(d) % 2) ^ flip;
    bits = {stop_v, par, d, 1'b0};
    if (abort_bit < 0) begin
      e.d  = d;
      e.pe = (($countones(d) + int'(par)) % 2) != 0;
      e.fe = !stop_v;
      // two synchroniser cycles, then valid 337 cycles after the rx_s edge
      e.at = cyc + 2 + 337;
      q.push_back(e);
    end
    for (int b = 0; b < 11; b++) begin
      rx = bits[b];
      if (b == abort_bit) begin
        idle(CPB / 2);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      idle(CPB);
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not end, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals();

    // 1: clean frame
    send_frame(8'hD1, 1'b0, 1'b1, -1);
    idle(20);
    chk("pending_t1", q.size(), 0);
    chk_held();

    // 2: parity error, flags must hold
    send_frame(8'h35, 1'b1, 1'b1, -1);
    idle(50);
    chk("pending_t2", q.size(), 0);
    chk_held();

    // 3: stop bit low, then a break, then a good frame
    send_frame(8'h4A, 1'b0, 1'b0, -1);
    idle(200);
    chk("break_busy", busy, 1'b1);
    chk("pending_t3a", q.size(), 0);
    rx = 1'b1;
    idle(10);
    chk("after_break_busy", busy, 1'b0);
    chk_held();
    send_frame(8'h5D, 1'b0, 1'b1, -1);
    idle(10);
    chk("pending_t3b", q.size(), 0);
    chk_held();

    // 4: short glitch
    rx = 1'b0;
    idle(10);
    rx = 1'b1;
    chk("glitch_busy_hi", busy, 1'b1);
    idle(40);
    chk("glitch_busy_lo", busy, 1'b0);
    chk("pending_t4", q.size(), 0);
    chk_held();

    // 5: back-to-back frames
    send_frame(8'h61, 1'b0, 1'b1, -1);
    send_frame(8'h7E, 1'b0, 1'b1, -1);
    idle(10);
    chk("pending_t5", q.size(), 0);
    chk_held();

    // 6: reset during data bit 4 (frame bit 5), then a good frame
    send_frame(8'h87, 1'b0, 1'b1, 5);
    chk_reset_vals();
    last_d  = 8'h00;
    last_pe = 1'b0;
    last_fe = 1'b0;
    idle(10);
    send_frame(8'h21, 1'b0, 1'b1, -1);
    idle(10);
    chk("pending_t6", q.size(), 0);
    chk_held();

    // random frames with occasional parity/stop errors and back-to-back gaps
    for (int i = 0; i < 24; i++) begin
      logic [7:0] d;
      bit         flip, stop_v;
      int         gap;
      d      = 8'($urandom);
      flip   = ($urandom_range(3) == 0);
      stop_v = ($urandom_range(4) != 0);
      gap    = $urandom_range(30);
      send_frame(d, flip, stop_v, -1);
      if (stop_v) begin
        chk("rand_busy_idle", busy, 1'b0);
        idle(gap);
      end else begin
        idle($urandom_range(120, 40));
        rx = 1'b1;
        idle(4 + gap);
      end
      if (gap > 2) chk_held();
    end
    idle(10);
    chk("pending_end", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
